// File: rtl/gtech_fd_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gtech_fd_pkg : shared helpers for the gtech_fd_pipe retiming block    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package gtech_fd_pkg;

    // Replicated across WIDTH to form the default per-lane reset value.
    localparam bit FD_RST_BIT = 1'b1;

    function automatic int fd_clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    function automatic bit fd_params_ok(input int width, input int channels, input int depth);
        return (width >= 1) && (channels >= 1) && (depth >= 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/gtech_fd_pipe_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gtech_fd_pipe_if : data/valid/control bundle of the flop pipeline     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface gtech_fd_pipe_if
    import gtech_fd_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4,
    parameter int DEPTH    = 3
);
    localparam int DW   = WIDTH * CHANNELS;
    localparam int OCCW = fd_clog2(DEPTH + 1);

    logic            EN;
    logic            CLR;
    logic            VI;
    logic [DW-1:0]   D;
    logic [DW-1:0]   Q;
    logic [DW-1:0]   QN;
    logic            VO;
    logic [OCCW-1:0] OCC;

    modport master (
        output EN, CLR, VI, D,
        input  Q, QN, VO, OCC
    );

    modport slave (
        input  EN, CLR, VI, D,
        output Q, QN, VO, OCC
    );

endinterface
`default_nettype wire

// File: rtl/gtech_fd_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gtech_fd_stage : one data+valid register stage, SD > CLR > EN         |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module gtech_fd_stage #(
    parameter int            DW      = 16,
    parameter logic [DW-1:0] RST_VAL = '1
) (
    input  wire logic          CP,
    input  wire logic          SD,
    input  wire logic          EN,
    input  wire logic          CLR,
    input  wire logic [DW-1:0] data_i,
    input  wire logic          valid_i,
    output logic      [DW-1:0] data_o,
    output logic               valid_o
);

    logic [DW-1:0] data_q;
    logic [DW-1:0] data_d;
    logic          valid_q;
    logic          valid_d;

    // CLR only touches the valid bit; data keeps following EN.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (EN) begin
            data_d  = data_i;
            valid_d = valid_i;
        end
        if (CLR) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge CP) begin
        if (!SD) begin
            data_q  <= RST_VAL;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule
`default_nettype wire

// File: rtl/gtech_fd_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gtech_fd_pipe : DEPTH-stage multi-lane flop pipeline with valid/OCC   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module gtech_fd_pipe
    import gtech_fd_pkg::*;
#(
    parameter int               WIDTH    = 4,
    parameter int               CHANNELS = 4,
    parameter int               DEPTH    = 3,
    parameter logic [WIDTH-1:0] RST_VAL  = {WIDTH{FD_RST_BIT}}
) (
    input  wire logic         CP,
    input  wire logic         SD,
    gtech_fd_pipe_if.slave    bus
);

    localparam int DW   = WIDTH * CHANNELS;
    localparam int OCCW = fd_clog2(DEPTH + 1);

    if (!fd_params_ok(WIDTH, CHANNELS, DEPTH)) begin : g_param_error
        $error("gtech_fd_pipe: WIDTH, CHANNELS and DEPTH must all be >= 1");
    end

    logic [DW-1:0]   w_data  [DEPTH+1];
    logic            w_valid [DEPTH+1];
    logic [OCCW-1:0] occ_q;
    logic [OCCW-1:0] occ_d;

    assign w_data[0]  = bus.D;
    assign w_valid[0] = bus.VI;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        gtech_fd_stage #(
            .DW      (DW),
            .RST_VAL ({CHANNELS{RST_VAL}})
        ) u_stage (
            .CP      (CP),
            .SD      (SD),
            .EN      (bus.EN),
            .CLR     (bus.CLR),
            .data_i  (w_data[i]),
            .valid_i (w_valid[i]),
            .data_o  (w_data[i+1]),
            .valid_o (w_valid[i+1])
        );
    end

    // A full pipe always has a valid last stage, so the shift update never overflows.
    always_comb begin
        occ_d = occ_q;
        if (bus.CLR) begin
            occ_d = '0;
        end else if (bus.EN) begin
            occ_d = occ_q + OCCW'(bus.VI) - OCCW'(w_valid[DEPTH]);
        end
    end

    always_ff @(posedge CP) begin
        if (!SD) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign bus.Q   = w_data[DEPTH];
    assign bus.QN  = ~w_data[DEPTH];
    assign bus.VO  = w_valid[DEPTH];
    assign bus.OCC = occ_q;

endmodule
`default_nettype wire

// File: tb/tb_gtech_fd_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_gtech_fd_pipe : directed self-checking bench for gtech_fd_pipe     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_gtech_fd_pipe;

    logic CP;
    logic SD;
    int   n_checks;
    int   n_fail;

    gtech_fd_pipe_if #(.WIDTH(4), .CHANNELS(4), .DEPTH(3)) bus ();

    gtech_fd_pipe #(
        .WIDTH    (4),
        .CHANNELS (4),
        .DEPTH    (3),
        .RST_VAL  (4'hF)
    ) dut (
        .CP  (CP),
        .SD  (SD),
        .bus (bus)
    );

    initial CP = 1'b0;
    always #5 CP = ~CP;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic sd, input logic en, input logic clr, input logic vi, input logic [15:0] d);
        SD      = sd;
        bus.EN  = en;
        bus.CLR = clr;
        bus.VI  = vi;
        bus.D   = d;
    endtask

    task automatic tick();
        @(posedge CP);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [15:0] q, input logic vo, input logic [1:0] occ);
        check_value({tag, ".Q"},   32'(bus.Q),   32'(q));
        check_value({tag, ".VO"},  32'(bus.VO),  32'(vo));
        check_value({tag, ".OCC"}, 32'(bus.OCC), 32'(occ));
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h1234);

        // Reset ignores D/VI
        tick();
        check_out("rst", 16'hFFFF, 1'b0, 2'd0);
        check_value("rst.QN", 32'(bus.QN), 32'h0000);

        // Single word through the pipe
        drive(1'b1, 1'b1, 1'b0, 1'b1, 16'hA5A5);
        tick();
        check_out("single.e1", 16'hFFFF, 1'b0, 2'd1);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
        tick();
        check_out("single.e2", 16'hFFFF, 1'b0, 2'd1);
        tick();
        check_out("single.e3", 16'hA5A5, 1'b1, 2'd1);
        check_value("single.QN", 32'(bus.QN), 32'h5A5A);
        tick();
        check_out("single.e4", 16'h0000, 1'b0, 2'd0);

        // Back-to-back words 1..4
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b1, 16'(i));
            tick();
            check_value("b2b.OCC", 32'(bus.OCC), (i < 3) ? 32'(i) : 32'd3);
            if (i >= 3) check_value("b2b.Q", 32'(bus.Q), 32'(i - 2));
        end
        drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
        tick();
        check_out("b2b.e5", 16'h0003, 1'b1, 2'd2);
        tick();
        check_out("b2b.e6", 16'h0004, 1'b1, 2'd1);
        tick();
        check_out("b2b.e7", 16'h0000, 1'b0, 2'd0);

        // Fill, stall 5 cycles with toggling inputs, resume
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b1, 16'(i * 16'h0011));
            tick();
        end
        check_out("stall.full", 16'h0011, 1'b1, 2'd3);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 1'b0, i[0], 16'hC000 + 16'(i));
            tick();
            check_out("stall.hold", 16'h0011, 1'b1, 2'd3);
        end
        drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
        tick();
        check_out("stall.r1", 16'h0022, 1'b1, 2'd2);
        tick();
        check_out("stall.r2", 16'h0033, 1'b1, 2'd1);
        tick();
        check_out("stall.r3", 16'h0000, 1'b0, 2'd0);

        // Flush with EN=1: data keeps moving, valids cleared
        for (int i = 4; i <= 6; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b1, 16'(i * 16'h0011));
            tick();
        end
        drive(1'b1, 1'b1, 1'b1, 1'b1, 16'hBEEF);
        tick();
        check_out("flush.e1", 16'h0055, 1'b0, 2'd0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
        tick();
        check_out("flush.e2", 16'h0066, 1'b0, 2'd0);
        tick();
        check_out("flush.e3", 16'hBEEF, 1'b0, 2'd0);

        // Flush while holding: data frozen, valids cleared
        drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h00AA);
        tick();
        tick();
        tick();
        drive(1'b1, 1'b0, 1'b1, 1'b1, 16'h1111);
        tick();
        check_out("flushhold", 16'h00AA, 1'b0, 2'd0);

        // Mid-stream reset beats CLR/EN, then clean restart
        drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h0077);
        tick();
        drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h0088);
        tick();
        drive(1'b0, 1'b1, 1'b1, 1'b1, 16'h9999);
        tick();
        check_out("midrst", 16'hFFFF, 1'b0, 2'd0);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 16'hABCD);
        tick();
        check_out("restart.e1", 16'hFFFF, 1'b0, 2'd1);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
        tick();
        tick();
        check_out("restart.e3", 16'hABCD, 1'b1, 2'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
